instr_fetch_unit: RTL

//  Fetch stage directly downstream of the program counter. Accepts PC values over a

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_fetch_queue.sv | 108 ++++++++++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch unit and its reservation queue.
package instr_fetch_unit_pkg;

    localparam int          DATA_WIDTH_32 = 32;
    localparam logic [31:0] NOP_INST_32   = 32'h0000_0013;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// In-order reservation FIFO: entries are allocated at PC acceptance and filled later,
// oldest unfilled first, as memory responses return.
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int             DW    = DATA_WIDTH_32,
    parameter int             DEPTH = 2,
    parameter logic [DW-1:0]  NOP   = NOP_INST_32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        alloc_i,
    input  logic [DW-1:0]               alloc_pc_i,
    input  logic                        alloc_fault_i,
    input  logic                        fill_i,
    input  logic [DW-1:0]               fill_data_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [cnt_width(DEPTH)-1:0] unfilled_cnt_o,
    output logic                        has_unfilled_o,
    output logic                        head_filled_o,
    output logic [DW-1:0]               head_pc_o,
    output logic [DW-1:0]               head_data_o,
    output logic                        head_fault_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);

    logic [DW-1:0]    pc_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] fault_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic             fill_found;
    logic [PW-1:0]    fill_idx;
    logic [PW-1:0]    scan_idx;
    logic [CW-1:0]    unfilled;

    // Walk from the head so the first unfilled entry found is the oldest outstanding read.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = head_q;
        scan_idx   = '0;
        unfilled   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && !filled_q[scan_idx]) begin
                unfilled = unfilled + CW'(1);
                if (!fill_found) begin
                    fill_found = 1'b1;
                    fill_idx   = scan_idx;
                end
            end
        end
    end

    // Payload storage carries no reset; validity is defined by count/filled only.
    always_ff @(posedge clk) begin
        if (alloc_i && !flush_i) begin
            pc_q[tail_q] <= alloc_pc_i;
            if (alloc_fault_i) begin
                data_q[tail_q] <= NOP;
            end
        end
        if (fill_i && fill_found && !flush_i) begin
            data_q[fill_idx] <= fill_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            filled_q <= '0;
            fault_q  <= '0;
        end else begin
            if (alloc_i) begin
                tail_q           <= tail_q + PW'(1);
                filled_q[tail_q] <= alloc_fault_i;
                fault_q[tail_q]  <= alloc_fault_i;
            end
            if (fill_i && fill_found) begin
                filled_q[fill_idx] <= 1'b1;
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(alloc_i) - CW'(pop_i);
        end
    end

    assign full_o         = (count_q == CW'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign unfilled_cnt_o = unfilled;
    assign has_unfilled_o = fill_found;
    assign head_filled_o  = filled_q[head_q];
    assign head_pc_o      = pc_q[head_q];
    assign head_data_o    = data_q[head_q];
    assign head_fault_o   = fault_q[head_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC handshake, in-order imem requests, misaligned-PC faulting and
// flush handling with a counter of stale responses still to be discarded.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_32,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = NOP_INST_32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  pc_valid,
    output logic                  pc_ready,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  inst_fault
);

    localparam int CW = cnt_width(DEPTH);

    logic          full;
    logic          empty;
    logic [CW-1:0] unfilled_cnt;
    logic          has_unfilled;
    logic          head_filled;
    logic          aligned;
    logic          accept;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_fill;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] drop_cnt_d;

    assign aligned        = is_aligned(pc_in[1:0]);
    assign imem_req_valid = pc_valid & aligned & ~full & ~flush & ~rst;
    assign pc_ready       = (aligned ? imem_req_ready : 1'b1) & ~full & ~flush & ~rst;
    assign imem_req_addr  = pc_in;
    assign accept         = pc_valid & pc_ready;

    assign inst_valid     = head_filled & ~empty & ~flush & ~rst;
    assign pop            = inst_valid & inst_ready;

    assign rsp_drop       = imem_rsp_valid & (drop_cnt_q != '0);
    assign rsp_fill       = imem_rsp_valid & (drop_cnt_q == '0) & ~flush;

    // On flush every outstanding read (already owed drops plus unfilled entries) becomes
    // stale, less the one returning right now.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = drop_cnt_q + unfilled_cnt - CW'(imem_rsp_valid);
        end else if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH),
        .NOP   (NOP_INST)
    ) u_queue (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .alloc_i        (accept),
        .alloc_pc_i     (pc_in),
        .alloc_fault_i  (~aligned),
        .fill_i         (rsp_fill),
        .fill_data_i    (imem_rsp_data),
        .pop_i          (pop),
        .full_o         (full),
        .empty_o        (empty),
        .unfilled_cnt_o (unfilled_cnt),
        .has_unfilled_o (has_unfilled),
        .head_filled_o  (head_filled),
        .head_pc_o      (inst_pc),
        .head_data_o    (inst_data),
        .head_fault_o   (inst_fault)
    );

    // A response must either be owed to a flushed fetch or have an entry waiting for it.
    assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> ((drop_cnt_q != '0) || has_unfilled));

endmodule
